// File: rtl/psk_phase_accum_mc.sv
// PSK phase accumulator: gated burst of sine-LUT addresses with
// per-discrete BPSK/QPSK keying from a Fibonacci LFSR.
module psk_phase_accum_mc #(
    parameter int                ADDR_W    = 12,
    parameter int                FRAC_W    = 14,
    parameter int                LFSR_W    = 10,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 10'h240,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h009,
    parameter int                DISC_W    = 16,
    parameter int                CODE_W    = 10,
    parameter int                CNT_W     = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     OUT_REG_READY,
    input  logic                     ABORT,
    input  logic                     MODE,
    input  logic [ADDR_W+FRAC_W-1:0] STEP,
    input  logic [DISC_W-1:0]        DISC_LEN,
    input  logic [CODE_W-1:0]        CODE_LEN,
    input  logic [CNT_W-1:0]         PERIOD_LEN,
    input  logic [4:0]               NUM_OF_IMP,
    output logic [ADDR_W-1:0]        ROM_ADDRESS,
    output logic                     ADDR_VALID,
    output logic                     GATE,
    output logic                     SIGN_START_CALC,
    output logic                     SIGN_STOP_CALC,
    output logic                     BUSY,
    output logic                     CFG_ERR
);
    localparam int ACC_W = ADDR_W + FRAC_W;
    localparam int IMP_W = DISC_W + CODE_W;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

    state_t state_q, state_d;

    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  step_q, step_d;
    logic [DISC_W-1:0] disc_q, disc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [4:0]        num_q, num_d;
    logic [CNT_W-1:0]  imp_q, imp_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  p_q, p_d;
    logic [DISC_W-1:0] dcnt_q, dcnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [1:0]        sym_q, sym_d;
    logic              err_q, err_d;
    logic              stop_q, stop_d;

    logic [IMP_W-1:0]  imp_calc;
    logic [CNT_W-1:0]  n_calc;
    logic              cfg_bad;
    logic              last;
    logic [CNT_W-1:0]  p_inc;
    logic [CNT_W-1:0]  p_nx;
    logic              gate;
    logic [ADDR_W-1:0] phase_hi;

    // One discrete's worth of code: one LFSR step for BPSK, two for QPSK.
    // Returns {b1, b0, next_lfsr}; BPSK places its bit in b1 with b0=0.
    function automatic logic [LFSR_W+1:0] code_step(
        input logic [LFSR_W-1:0] s,
        input logic              qpsk
    );
        logic [LFSR_W-1:0] r;
        logic              b1;
        logic              b0;
        b1 = ^(s & LFSR_TAPS);
        r  = {s[LFSR_W-2:0], b1};
        b0 = ^(r & LFSR_TAPS);
        if (qpsk) begin
            r = {r[LFSR_W-2:0], b0};
            return {b1, b0, r};
        end
        return {b1, 1'b0, r};
    endfunction

    // Burst geometry and validation, evaluated from the latched config.
    always_comb begin
        imp_calc = IMP_W'(disc_q) * IMP_W'(code_q);
        n_calc   = (CNT_W'(num_q) - CNT_W'(1)) * period_q
                 + CNT_W'(imp_calc);
        cfg_bad  = (disc_q == '0) || (code_q == '0) || (num_q == '0)
                 || ((num_q > 5'd1) && (period_q < CNT_W'(imp_calc)));
        last     = (k_q == n_q - CNT_W'(1));
        p_inc    = p_q + CNT_W'(1);
        p_nx     = ((num_q > 5'd1) && (p_inc == period_q)) ? '0 : p_inc;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (START && OUT_REG_READY) state_d = S_SETUP;
            S_SETUP: state_d = cfg_bad ? S_IDLE : S_RUN;
            S_RUN:   if (last || ABORT) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next state: config latch, setup, per-sample advance.
    always_comb begin
        mode_d   = mode_q;
        step_d   = step_q;
        disc_d   = disc_q;
        code_d   = code_q;
        period_d = period_q;
        num_d    = num_q;
        imp_d    = imp_q;
        n_d      = n_q;
        k_d      = k_q;
        p_d      = p_q;
        dcnt_d   = dcnt_q;
        acc_d    = acc_q;
        lfsr_d   = lfsr_q;
        sym_d    = sym_q;
        err_d    = 1'b0;
        stop_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START && OUT_REG_READY) begin
                    mode_d   = MODE;
                    step_d   = STEP;
                    disc_d   = DISC_LEN;
                    code_d   = CODE_LEN;
                    period_d = PERIOD_LEN;
                    num_d    = NUM_OF_IMP;
                end
            end
            S_SETUP: begin
                imp_d  = CNT_W'(imp_calc);
                n_d    = n_calc;
                err_d  = cfg_bad;
                k_d    = '0;
                p_d    = '0;
                dcnt_d = '0;
                acc_d  = '0;
                {sym_d, lfsr_d} = code_step(LFSR_SEED, mode_q);
            end
            S_RUN: begin
                stop_d = ABORT && !last;
                k_d    = k_q + CNT_W'(1);
                p_d    = p_nx;
                if (p_nx == '0) begin
                    // Every impulse restarts phase and code from the seed.
                    acc_d  = '0;
                    dcnt_d = '0;
                    {sym_d, lfsr_d} = code_step(LFSR_SEED, mode_q);
                end else begin
                    acc_d = acc_q + step_q;
                    if (dcnt_q + DISC_W'(1) == disc_q) begin
                        dcnt_d = '0;
                        {sym_d, lfsr_d} = code_step(lfsr_q, mode_q);
                    end else begin
                        dcnt_d = dcnt_q + DISC_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q   <= 1'b0;
            step_q   <= '0;
            disc_q   <= '0;
            code_q   <= '0;
            period_q <= '0;
            num_q    <= '0;
            imp_q    <= '0;
            n_q      <= '0;
            k_q      <= '0;
            p_q      <= '0;
            dcnt_q   <= '0;
            acc_q    <= '0;
            lfsr_q   <= '0;
            sym_q    <= '0;
            err_q    <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            step_q   <= step_d;
            disc_q   <= disc_d;
            code_q   <= code_d;
            period_q <= period_d;
            num_q    <= num_d;
            imp_q    <= imp_d;
            n_q      <= n_d;
            k_q      <= k_d;
            p_q      <= p_d;
            dcnt_q   <= dcnt_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
            sym_q    <= sym_d;
            err_q    <= err_d;
            stop_q   <= stop_d;
        end
    end

    // Outputs; the symbol offset only touches the top address bits.
    always_comb begin
        gate            = (state_q == S_RUN) && (p_q < imp_q);
        phase_hi        = acc_q[ACC_W-1:FRAC_W]
                        + {sym_q, {(ADDR_W-2){1'b0}}};
        ROM_ADDRESS     = gate ? phase_hi : '0;
        GATE            = gate;
        ADDR_VALID      = (state_q == S_RUN);
        SIGN_START_CALC = (state_q == S_RUN) && (k_q == '0);
        SIGN_STOP_CALC  = ((state_q == S_RUN) && last) || stop_q;
        BUSY            = (state_q != S_IDLE);
        CFG_ERR         = err_q;
    end
endmodule

// File: tb/tb_psk_phase_accum_mc.sv
// Bench for psk_phase_accum_mc: fixed scenarios plus randomized
// bursts against a behavioural model of the address sequence.
module tb_psk_phase_accum_mc;
    localparam int ACC_W = 26;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        OUT_REG_READY = 1'b1;
    logic        ABORT = 1'b0;
    logic        MODE = 1'b0;
    logic [25:0] STEP = '0;
    logic [15:0] DISC_LEN = '0;
    logic [9:0]  CODE_LEN = '0;
    logic [31:0] PERIOD_LEN = '0;
    logic [4:0]  NUM_OF_IMP = '0;
    logic [11:0] ROM_ADDRESS;
    logic        ADDR_VALID, GATE, SIGN_START_CALC;
    logic        SIGN_STOP_CALC, BUSY, CFG_ERR;

    int checks = 0;
    int failures = 0;

    bit          c_mode;
    logic [25:0] c_step;
    int          c_disc, c_code, c_period, c_num;

    logic [11:0] o_addr [512];
    logic        o_val [512];
    logic        o_gate [512];
    logic        o_sst [512];
    logic        o_stp [512];
    logic        o_busy [512];
    logic        o_err [512];

    int e_addr [512];
    bit e_gate [512];
    int n_exp;

    psk_phase_accum_mc #(.LFSR_SEED(10'h200)) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .OUT_REG_READY(OUT_REG_READY), .ABORT(ABORT), .MODE(MODE),
        .STEP(STEP), .DISC_LEN(DISC_LEN), .CODE_LEN(CODE_LEN),
        .PERIOD_LEN(PERIOD_LEN), .NUM_OF_IMP(NUM_OF_IMP),
        .ROM_ADDRESS(ROM_ADDRESS), .ADDR_VALID(ADDR_VALID),
        .GATE(GATE), .SIGN_START_CALC(SIGN_START_CALC),
        .SIGN_STOP_CALC(SIGN_STOP_CALC), .BUSY(BUSY), .CFG_ERR(CFG_ERR)
    );

    always #5 CLK = ~CLK;

    // Reference: code bits from the tap rule, address from p*STEP + offset.
    task automatic model();
        logic [9:0] s;
        bit         fb;
        bit         bits [2048];
        int         imp, p, d, sym;
        longint     v;
        imp = c_disc * c_code;
        n_exp = (c_num - 1) * c_period + imp;
        s = 10'h200;
        for (int i = 0; i < 2 * c_code; i++) begin
            fb = ^(s & 10'h240);
            s = {s[8:0], fb};
            bits[i] = fb;
        end
        for (int k = 0; k < n_exp; k++) begin
            p = (c_num > 1) ? k % c_period : k;
            if (p < imp) begin
                d = p / c_disc;
                sym = c_mode ? (2 * bits[2*d] + bits[2*d+1])
                             : 2 * bits[d];
                v = longint'(p) * longint'(c_step)
                  + (longint'(sym) << (ACC_W - 2));
                v = v & ((64'd1 << ACC_W) - 1);
                e_addr[k] = int'(v >> 14);
                e_gate[k] = 1'b1;
            end else begin
                e_addr[k] = 0;
                e_gate[k] = 1'b0;
            end
        end
    endtask

    task automatic drive_cfg();
        MODE = c_mode;
        STEP = c_step;
        DISC_LEN = c_disc[15:0];
        CODE_LEN = c_code[9:0];
        PERIOD_LEN = c_period;
        NUM_OF_IMP = c_num[4:0];
    endtask

    task automatic scramble();
        MODE = 1'($urandom);
        STEP = 26'($urandom);
        DISC_LEN = 16'($urandom);
        CODE_LEN = 10'($urandom);
        PERIOD_LEN = $urandom;
        NUM_OF_IMP = 5'($urandom);
    endtask

    task automatic set_t1();
        c_mode = 0; c_step = 26'd16384; c_disc = 2;
        c_code = 3; c_period = 10; c_num = 2;
    endtask

    // Start a burst and record ncyc cycles after the accepting edge.
    task automatic capture(input int ncyc, input int start_c,
                           input int abort_c, input int reset_c);
        @(negedge CLK);
        drive_cfg();
        START = 1'b1;
        OUT_REG_READY = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK);
            o_addr[c] = ROM_ADDRESS;
            o_val[c]  = ADDR_VALID;
            o_gate[c] = GATE;
            o_sst[c]  = SIGN_START_CALC;
            o_stp[c]  = SIGN_STOP_CALC;
            o_busy[c] = BUSY;
            o_err[c]  = CFG_ERR;
            START = (c == start_c);
            if (c == start_c) drive_cfg();
            else scramble();
            ABORT = (c == abort_c);
            RESET = (c == reset_c);
        end
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({ROM_ADDRESS, ADDR_VALID, GATE, SIGN_START_CALC,
             SIGN_STOP_CALC, BUSY, CFG_ERR} !== 18'd0) begin
            failures++;
            $display("FAIL reset: outs=%h want 0",
                {ROM_ADDRESS, ADDR_VALID, GATE, SIGN_START_CALC,
                 SIGN_STOP_CALC, BUSY, CFG_ERR});
        end
        RESET = 1'b0;
    endtask

    task automatic test_bpsk();
        int tbl [16] = '{2048, 2049, 2, 3, 4, 5, 0, 0,
                         0, 0, 2048, 2049, 2, 3, 4, 5};
        set_t1();
        model();
        capture(n_exp + 2, -1, -1, -1);
        checks++;
        if (o_busy[1] !== 1'b1 || o_val[1] !== 1'b0) begin
            failures++;
            $display("FAIL bpsk_setup: busy=%b val=%b want 1 0",
                o_busy[1], o_val[1]);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_addr[2+k] !== 12'(tbl[k]) || o_gate[2+k] !== (k % 10 < 6)
                || o_sst[2+k] !== (k == 0) || o_stp[2+k] !== (k == 15)
                || o_val[2+k] !== 1'b1) begin
                failures++;
                $display("FAIL bpsk k=%0d: addr=%0d gate=%b st=%b sp=%b v=%b want addr=%0d",
                    k, o_addr[2+k], o_gate[2+k], o_sst[2+k], o_stp[2+k],
                    o_val[2+k], tbl[k]);
            end
        end
        checks++;
        if ({o_val[18], o_busy[18], o_stp[18], o_gate[18]} !== 4'd0) begin
            failures++;
            $display("FAIL bpsk_tail: v=%b b=%b sp=%b g=%b want 0",
                o_val[18], o_busy[18], o_stp[18], o_gate[18]);
        end
    endtask

    task automatic test_qpsk();
        c_mode = 1; c_step = '0; c_disc = 1;
        c_code = 2; c_period = 7; c_num = 1;
        model();
        capture(n_exp + 2, -1, -1, -1);
        checks++;
        if (o_addr[2] !== 12'd2048 || o_addr[3] !== 12'd0
            || o_val[3] !== 1'b1 || o_stp[3] !== 1'b1
            || o_val[4] !== 1'b0) begin
            failures++;
            $display("FAIL qpsk: a0=%0d a1=%0d v1=%b sp1=%b v2=%b want 2048 0 1 1 0",
                o_addr[2], o_addr[3], o_val[3], o_stp[3], o_val[4]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            c_mode = 1'($urandom);
            c_step = 26'($urandom);
            c_disc = $urandom_range(1, 4);
            c_code = $urandom_range(1, 8);
            c_num = $urandom_range(1, 3);
            c_period = (c_num > 1)
                ? c_disc * c_code + $urandom_range(0, 4)
                : $urandom_range(0, 20);
            model();
            capture(n_exp + 2, -1, -1, -1);
            for (int k = 0; k < n_exp; k++) begin
                checks++;
                if (o_addr[2+k] !== 12'(e_addr[k])
                    || o_gate[2+k] !== e_gate[k] || o_val[2+k] !== 1'b1
                    || o_sst[2+k] !== (k == 0)
                    || o_stp[2+k] !== (k == n_exp - 1)) begin
                    failures++;
                    $display("FAIL random it=%0d k=%0d: addr=%0d gate=%b v=%b st=%b sp=%b want addr=%0d gate=%b",
                        it, k, o_addr[2+k], o_gate[2+k], o_val[2+k],
                        o_sst[2+k], o_stp[2+k], e_addr[k], e_gate[k]);
                end
            end
            checks++;
            if (o_val[n_exp+2] !== 1'b0 || o_busy[n_exp+2] !== 1'b0) begin
                failures++;
                $display("FAIL random_tail it=%0d: v=%b b=%b want 0 0",
                    it, o_val[n_exp+2], o_busy[n_exp+2]);
            end
        end
    endtask

    task automatic test_cfg_err();
        for (int cs = 0; cs < 2; cs++) begin
            set_t1();
            if (cs == 0) c_code = 0;
            else c_period = 5;
            capture(4, 2, -1, -1);
            checks++;
            if (o_busy[1] !== 1'b1 || o_err[1] !== 1'b0
                || o_err[2] !== 1'b1 || o_busy[2] !== 1'b0
                || o_err[3] !== 1'b0 || o_busy[3] !== 1'b1
                || o_err[4] !== 1'b1) begin
                failures++;
                $display("FAIL cfg_err case=%0d: busy=%b%b%b err=%b%b%b%b want 101 0101",
                    cs, o_busy[1], o_busy[2], o_busy[3],
                    o_err[1], o_err[2], o_err[3], o_err[4]);
            end
            checks++;
            if ({o_val[1], o_val[2], o_val[3], o_val[4]} !== 4'd0) begin
                failures++;
                $display("FAIL cfg_err_valid case=%0d: v=%b%b%b%b want 0000",
                    cs, o_val[1], o_val[2], o_val[3], o_val[4]);
            end
        end
    endtask

    task automatic test_handshake();
        int n;
        @(negedge CLK);
        set_t1();
        drive_cfg();
        START = 1'b1;
        OUT_REG_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || ADDR_VALID !== 1'b0) begin
                failures++;
                $display("FAIL not_ready i=%0d: busy=%b v=%b want 0 0",
                    i, BUSY, ADDR_VALID);
            end
        end
        START = 1'b0;
        OUT_REG_READY = 1'b1;
        model();
        n = n_exp;
        capture(n + 3, 4, -1, -1);
        checks++;
        if (o_stp[n+1] !== 1'b1 || o_val[n+1] !== 1'b1
            || o_val[n+2] !== 1'b0 || o_busy[n+3] !== 1'b0) begin
            failures++;
            $display("FAIL start_busy: sp=%b v=%b v+1=%b b+2=%b want 1 1 0 0",
                o_stp[n+1], o_val[n+1], o_val[n+2], o_busy[n+3]);
        end
        capture(2 * n + 4, n + 2, -1, -1);
        checks++;
        if (o_busy[n+2] !== 1'b0 || o_val[n+2] !== 1'b0
            || o_busy[n+3] !== 1'b1 || o_val[n+3] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: busy=%b%b v=%b%b want 01 00",
                o_busy[n+2], o_busy[n+3], o_val[n+2], o_val[n+3]);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (o_addr[n+4+k] !== 12'(e_addr[k]) || o_val[n+4+k] !== 1'b1
                || o_sst[n+4+k] !== (k == 0)
                || o_stp[n+4+k] !== (k == n - 1)) begin
                failures++;
                $display("FAIL b2b k=%0d: addr=%0d v=%b st=%b sp=%b want addr=%0d",
                    k, o_addr[n+4+k], o_val[n+4+k], o_sst[n+4+k],
                    o_stp[n+4+k], e_addr[k]);
            end
        end
        checks++;
        if (o_val[2*n+4] !== 1'b0 || o_busy[2*n+4] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tail: v=%b b=%b want 0 0",
                o_val[2*n+4], o_busy[2*n+4]);
        end
    endtask

    task automatic test_abort();
        set_t1();
        model();
        capture(n_exp + 2, -1, 6, -1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_addr[2+k] !== 12'(e_addr[k]) || o_val[2+k] !== 1'b1
                || o_sst[2+k] !== (k == 0) || o_stp[2+k] !== 1'b0) begin
                failures++;
                $display("FAIL abort_pre k=%0d: addr=%0d v=%b st=%b sp=%b want addr=%0d",
                    k, o_addr[2+k], o_val[2+k], o_sst[2+k], o_stp[2+k],
                    e_addr[k]);
            end
        end
        checks++;
        if (o_val[7] !== 1'b0 || o_gate[7] !== 1'b0 || o_addr[7] !== '0
            || o_busy[7] !== 1'b0 || o_stp[7] !== 1'b1
            || o_stp[8] !== 1'b0) begin
            failures++;
            $display("FAIL abort_stop: v=%b g=%b a=%0d b=%b sp=%b%b want 0 0 0 0 10",
                o_val[7], o_gate[7], o_addr[7], o_busy[7], o_stp[7], o_stp[8]);
        end
        capture(n_exp + 2, -1, -1, -1);
        checks++;
        if (o_addr[2] !== 12'd2048 || o_sst[2] !== 1'b1
            || o_stp[n_exp+1] !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart: a=%0d st=%b sp=%b want 2048 1 1",
                o_addr[2], o_sst[2], o_stp[n_exp+1]);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        set_t1();
        model();
        capture(n_exp + 2, -1, -1, 9);
        bad = 1'b0;
        for (int c = 10; c <= n_exp + 2; c++)
            if ({o_val[c], o_gate[c], o_sst[c], o_stp[c], o_busy[c],
                 o_err[c], o_addr[c]} !== 18'd0) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid: v=%b sp=%b b=%b a=%0d at first post-reset cycle, want all 0",
                o_val[10], o_stp[10], o_busy[10], o_addr[10]);
        end
        capture(n_exp + 2, -1, -1, -1);
        for (int k = 0; k < n_exp; k++) begin
            checks++;
            if (o_addr[2+k] !== 12'(e_addr[k]) || o_gate[2+k] !== e_gate[k]
                || o_sst[2+k] !== (k == 0)
                || o_stp[2+k] !== (k == n_exp - 1)) begin
                failures++;
                $display("FAIL reset_rerun k=%0d: addr=%0d g=%b st=%b sp=%b want addr=%0d g=%b",
                    k, o_addr[2+k], o_gate[2+k], o_sst[2+k], o_stp[2+k],
                    e_addr[k], e_gate[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bpsk();
        test_qpsk();
        test_cfg_err();
        test_handshake();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psk_phase_accum_mc.md
# psk_phase_accum_mc

Parametrised PSK phase accumulator for the DDS signal path, successor to the fixed 12-bit BPSK accumulator. It generates a gated burst of ROM phase addresses for the sine LUT, with per-discrete phase keying from a configurable Fibonacci LFSR. It supports BPSK and QPSK, sample-domain timing inputs with no dividers in the datapath, abort, and configuration checking. It sits between the control register block and the output register and LUT.

## Interface
Parameters:
- ADDR_W, 12: ROM address width.
- FRAC_W, 14: accumulator fractional bits. The accumulator width is ACC_W = ADDR_W+FRAC_W.
- LFSR_W, 10: M-sequence register length.
- LFSR_TAPS, 10'h240: feedback tap mask (bits 9 and 6).
- LFSR_SEED, 10'h009: register value at the start of every impulse.
- DISC_W, 16: samples-per-discrete width.
- CODE_W, 10: code length width.
- CNT_W, 32: sample counter width.

Ports:
- CLK, in, 1: clock.
- RESET, in, 1: reset, synchronous, active-high; clock CLK.
- START, in, 1: burst request. Sampled only in IDLE.
- OUT_REG_READY, in, 1: downstream ready. Checked only together with START.
- ABORT, in, 1: terminate the running burst.
- MODE, in, 1: 0 selects BPSK, 1 selects QPSK.
- STEP, in, ACC_W: phase increment per sample.
- DISC_LEN, in, DISC_W: samples per discrete.
- CODE_LEN, in, CODE_W: discretes per impulse.
- PERIOD_LEN, in, CNT_W: samples per repetition period.
- NUM_OF_IMP, in, 5: impulses per burst.
- ROM_ADDRESS, out, ADDR_W: LUT address. Reset value 0.
- ADDR_VALID, out, 1: ROM_ADDRESS carries a burst sample. Reset value 0.
- GATE, out, 1: current sample is inside an impulse. Reset value 0.
- SIGN_START_CALC, out, 1: one-cycle pulse on the first sample. Reset value 0.
- SIGN_STOP_CALC, out, 1: one-cycle pulse on the last sample or on abort. Reset value 0.
- BUSY, out, 1: high in SETUP and RUN. Reset value 0.
- CFG_ERR, out, 1: one-cycle pulse when a configuration is rejected. Reset value 0.

## Operation
- States are IDLE, SETUP and RUN.
- IDLE to SETUP: START=1 and OUT_REG_READY=1 at a clock edge. All configuration inputs are latched on that edge; later changes to them are ignored until the next acceptance.
- SETUP (one cycle):
  - Compute IMP = DISC_LEN*CODE_LEN.
  - Compute N = (NUM_OF_IMP-1)*PERIOD_LEN + IMP, truncated to CNT_W bits.
  - Validate. The configuration is an error if DISC_LEN=0, CODE_LEN=0, NUM_OF_IMP=0, or (NUM_OF_IMP>1 and PERIOD_LEN<IMP).
  - On error: pulse CFG_ERR and return to IDLE. Otherwise go to RUN.
- LFSR step:
  - fb = XOR-reduce(lfsr & LFSR_TAPS).
  - lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - The code bit produced is fb.
  - BPSK uses one step per discrete, giving bit b.
  - QPSK uses two steps per discrete: the first bit is b1, the second is b0.
- Phase offset, absolute rather than cumulative:
  - BPSK: OFF = b·2^(ACC_W-1).
  - QPSK: OFF = {b1,b0}·2^(ACC_W-2).
- RUN emits exactly N samples, at sample indices k = 0..N-1.
  - Position within the period: p = k mod PERIOD_LEN. For NUM_OF_IMP=1, p = k.
  - When p < IMP:
    - GATE=1.
    - ROM_ADDRESS = (acc + OFF)[ACC_W-1:FRAC_W], modulo 2^ACC_W.
    - acc is 0 at p=0 and increases by STEP each in-impulse sample.
    - The discrete changes every DISC_LEN samples.
  - When p ≥ IMP: GATE=0 and ROM_ADDRESS=0.
  - At p=0 of each impulse, the LFSR reloads LFSR_SEED and is stepped for the first discrete. Every impulse therefore carries an identical code.
  - The code repeats naturally if CODE_LEN exceeds 2^LFSR_W-1.
- Non-IDLE behaviour:
  - START is ignored outside IDLE.
  - ABORT is ignored outside RUN.
  - If ABORT and the last sample coincide, the last sample is emitted normally.
- RESET: next edge forces IDLE, clears all outputs and internal state. It produces no STOP pulse, including when asserted mid-burst.

## Timing
- START accepted at edge T:
  - Cycle T+1: SETUP, BUSY=1.
  - Cycle T+2: first sample. ADDR_VALID=1 and SIGN_START_CALC=1 in this cycle only.
- Samples occupy cycles T+2 .. T+N+1, with ADDR_VALID continuously high.
- SIGN_STOP_CALC=1 on cycle T+N+1, coincident with the last sample.
- Cycle T+N+2: IDLE, all outputs 0. A START sampled at the edge ending this cycle is accepted, giving a back-to-back gap of 1 idle cycle.
- Config error: CFG_ERR=1 on cycle T+2, BUSY=0 from T+2, no ADDR_VALID.
- ABORT sampled at edge A during RUN:
  - Cycle A+1: ADDR_VALID=0, GATE=0, ROM_ADDRESS=0, BUSY=0, SIGN_STOP_CALC=1.
  - Cycle A+2: SIGN_STOP_CALC=0.

## Test plan
1. BPSK burst. LFSR_SEED=10'h200 (bits 1,0,0), STEP=16384, DISC_LEN=2, CODE_LEN=3, PERIOD_LEN=10, NUM_OF_IMP=2 -> 16 valid samples with ROM_ADDRESS 2048,2049,2,3,4,5,0,0,0,0,2048,2049,2,3,4,5. GATE matches the impulse positions. START pulse on sample 1, STOP pulse on sample 16.
2. QPSK. LFSR_SEED=10'h200, MODE=1, STEP=0, DISC_LEN=1, CODE_LEN=2, NUM_OF_IMP=1 -> ROM_ADDRESS 2048 then 0. N=2.
3. Config error: CODE_LEN=0, then separately PERIOD_LEN=5 with IMP=6 and NUM_OF_IMP=2 -> CFG_ERR pulse at T+2, no ADDR_VALID, next START accepted.
4. Handshake: START with OUT_REG_READY=0 held for 5 cycles -> stays IDLE. START while BUSY -> ignored, burst length unchanged. Back-to-back STARTs -> exactly 1 idle cycle between bursts.
5. ABORT on the 5th sample of test 1 -> 5 valid samples, then an invalid cycle carrying the STOP pulse, BUSY=0. A new burst then restarts at address 2048.
6. RESET on the 8th sample of test 1 -> all outputs 0 on the next cycle, no STOP pulse. A subsequent burst is bit-identical to test 1.
